eth_ip_dst_extractor: RTL and testbench
=======================================

// Module: eth_ip_dst_extractor
// PURPOSE
// Upstream of the TX buffer controller: snoops the RX byte stream that is also written into the TX buffer FIFO.
// Classifies each frame as IPv4, IPv6 or non-IP, and extracts the IP destination address.
// Issues exactly one decision pulse per frame (ip_valid or non_ip_valid), so the buffer controller can start draining.
// PARAMETERS
// RGMII_W     8   byte-stream data width; only 8 is supported
// CNT_W       6   byte-offset counter width; saturates at 2**CNT_W-1; must cover offset 57
// VLAN_EN     1   1: skip one 802.1Q tag (TPID 0x8100); 0: treat 0x8100 as non-IP
// PORTS
// clk           in   1    core clock
// rst           in   1    asynchronous reset, active-low (asserted when 0)
// rx_valid      in   1    byte strobe; frame = contiguous run of rx_valid=1, first byte = dst MAC[0] (no preamble/SFD)
// rx_data       in   8    frame byte
// ip_valid      out  1    one-cycle pulse: IP dst address captured
// ip_is_ipv6    out  1    qualifies ip_valid/dst_ip; held until next decision
// dst_ip        out  128  IPv6 addr, or IPv4 addr in [31:0] with [127:32]=0; held until next decision
// non_ip_valid  out  1    one-cycle pulse: frame is not IPv4/IPv6, or truncated before the address completes
// trunc         out  1    qualifies non_ip_valid: 1 = frame ended early; held until next decision
// BEHAVIOUR
// - Reset: ip_valid=0, non_ip_valid=0, ip_is_ipv6=0, trunc=0, dst_ip=0, state=IDLE, counter=0.
// - Frame start: rx_valid=1 while the registered previous rx_valid=0.
//   - Valid already high when reset releases: frame is ignored until rx_valid drops.
// - Byte offset counter: 0 on the first byte, +1 per accepted byte, saturating.
// - L3 offset L = 14 without a tag, or 18 with a VLAN tag.
// - FSM states and transitions:
//   - IDLE -> ETH_HDR on frame start.
//   - ETH_HDR: type = bytes 12..13.
//     - type 0x8100 and VLAN_EN: go to VLAN; real type = bytes 16..17.
//     - 0x0800 -> IPV4; 0x86DD -> IPV6; any other type -> decide non-IP, go to WAIT_END.
//   - VLAN: same type decode on bytes 16..17.
//     - A second 0x8100 tag is treated as non-IP.
//   - IPV4 / IPV6: byte L high nibble must be 4 / 6; mismatch -> non-IP, go to WAIT_END.
//     - IPv4: dst = bytes L+16..L+19.
//     - IPv6: dst = bytes L+24..L+39.
//     - Bytes shift in MSB-first (first byte -> dst_ip[31:24] / [127:120]).
//     - Last dst byte accepted -> go to WAIT_END.
//   - WAIT_END: ignore bytes until rx_valid=0, then go to IDLE.
// - Latency: the decision pulse is registered, asserted the cycle after the deciding byte is accepted.
//   - IPv4 untagged: ip_valid in the cycle after offset 33 is accepted.
//   - IPv6 untagged: ip_valid in the cycle after offset 53 is accepted.
//   - dst_ip and ip_is_ipv6 update in the same cycle as the pulse.
// - Truncation: rx_valid=0 in ETH_HDR, VLAN, IPV4 or IPV6 gives non_ip_valid=1, trunc=1 next cycle, then IDLE.
//   - No partial dst_ip is published.
// - Last dst byte accepted in the same cycle that rx_valid then falls: the result is a normal ip_valid, not truncation.
// - Exactly one of ip_valid / non_ip_valid per started frame; never both in the same cycle.
// - Back-to-back frames need at least one idle cycle (rx_valid=0) between them.
//   - The outputs of frame N are not overwritten before frame N+1 decides.
// - Reset mid-frame: all outputs clear asynchronously; no pulse for the aborted frame.
// - Counter saturation is harmless: every decision completes by offset 57 (tagged IPv6).
// STRUCTURE
// - eth_pkg (shared): ETHERTYPE_IPV4=16'h0800, ETHERTYPE_IPV6=16'h86DD, ETHERTYPE_VLAN=16'h8100.
//   - Also in eth_pkg: ETH_HDR_LEN=14, VLAN_TAG_LEN=4, IPV4_DST_OFS=16, IPV6_DST_OFS=24.
//   - Also in eth_pkg: onehot enum ip_extract_state_t {IDLE, ETH_HDR, VLAN, IPV4, IPV6, WAIT_END}.
//   - The TX buffer controller reuses these IPv4/IPv6 delay constants.
// - One sub-module: byte_shift_capture (WIDTH=128).
//   - Ports: clk, rst, shift_en, clr, byte_in, word_out.
//   - Used for dst accumulation; ethertype decode uses a 16-bit holding reg in the top.
// TESTING
// - Untagged IPv4 frame, dst 192.168.1.10:
//   -> one ip_valid 1 cycle after offset 33; ip_is_ipv6=0; dst_ip[31:0]=32'hC0A8010A; upper bits 0.
// - Untagged IPv6 frame, dst 2001:db8::1:
//   -> ip_valid 1 cycle after offset 53; dst_ip=128'h20010DB8_00000000_00000000_00000001.
// - ARP frame (type 0x0806):
//   -> non_ip_valid 1 cycle after offset 13; trunc=0; no ip_valid.
//   - Same with VLAN tag 0x8100 + IPv4 -> ip_valid after offset 37.
// - IPv4 frame ending after 25 bytes -> non_ip_valid=1, trunc=1 one cycle after rx_valid falls.
//   - Type 0x0800 with version nibble 6 -> non_ip_valid, trunc=0.
// - Back-to-back IPv4 then IPv6, one idle cycle between -> two correct decisions in order.
//   - rst=0 at offset 20 -> outputs 0 immediately, no pulse.
//   - Frame already in flight at rst release is ignored; the next frame decodes normally.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet/IP constants and the extractor FSM state type.
// Imported by the destination-address extractor and reused by the
// TX buffer controller, which needs the same decision offsets.
package eth_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETHERTYPE_IPV6 = 16'h86DD;
    localparam logic [15:0] ETHERTYPE_VLAN = 16'h8100;

    localparam int unsigned ETH_HDR_LEN     = 14;
    localparam int unsigned VLAN_TAG_LEN    = 4;
    localparam int unsigned IPV4_DST_OFS    = 16;
    localparam int unsigned IPV6_DST_OFS    = 24;
    localparam int unsigned IPV4_ADDR_BYTES = 4;
    localparam int unsigned IPV6_ADDR_BYTES = 16;

    // Frame offset of the last destination byte for untagged frames;
    // add VLAN_TAG_LEN for tagged frames.
    localparam int unsigned IPV4_DECIDE_OFS = ETH_HDR_LEN + IPV4_DST_OFS + IPV4_ADDR_BYTES - 1;
    localparam int unsigned IPV6_DECIDE_OFS = ETH_HDR_LEN + IPV6_DST_OFS + IPV6_ADDR_BYTES - 1;

    typedef enum logic [5:0] {
        IDLE     = 6'b000001,
        ETH_HDR  = 6'b000010,
        VLAN     = 6'b000100,
        IPV4     = 6'b001000,
        IPV6     = 6'b010000,
        WAIT_END = 6'b100000
    } ip_extract_state_t;

    // IP version field lives in the high nibble of the first L3 byte.
    function automatic logic [3:0] ip_version(input logic [7:0] first_l3_byte);
        return first_l3_byte[7:4];
    endfunction

endpackage

// File: rtl/eth_ip_dst_extractor_if.sv
// Bus between the RX byte snooper and the extractor.
//   rx_valid/rx_data            : byte stream (driven by master)
//   ip_valid/ip_is_ipv6/dst_ip  : IP decision and captured address (driven by slave)
//   non_ip_valid/trunc          : non-IP / truncated decision (driven by slave)
interface eth_ip_dst_extractor_if #(
    parameter int unsigned RGMII_W = 8
);
    logic               rx_valid;
    logic [RGMII_W-1:0] rx_data;
    logic               ip_valid;
    logic               ip_is_ipv6;
    logic [127:0]       dst_ip;
    logic               non_ip_valid;
    logic               trunc;

    modport master (
        output rx_valid, rx_data,
        input  ip_valid, ip_is_ipv6, dst_ip, non_ip_valid, trunc
    );

    modport slave (
        input  rx_valid, rx_data,
        output ip_valid, ip_is_ipv6, dst_ip, non_ip_valid, trunc
    );
endinterface

// File: rtl/byte_shift_capture.sv
// MSB-first byte accumulator: each shift_en pushes byte_in into the low
// byte and moves older bytes up. clr has priority over shift_en.
//   clk, rst (async, active-low), shift_en, clr, byte_in[7:0], word_out[WIDTH-1:0]
module byte_shift_capture #(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clr,
    input  logic [7:0]       byte_in,
    output logic [WIDTH-1:0] word_out
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    always_comb begin
        word_d = word_q;
        if (clr) begin
            word_d = '0;
        end else if (shift_en) begin
            word_d = {word_q[WIDTH-9:0], byte_in};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_out = word_q;

endmodule

// File: rtl/eth_ip_dst_extractor.sv
// Snoops the RX byte stream, classifies each frame as IPv4 / IPv6 / non-IP
// and extracts the IP destination address. Exactly one registered decision
// pulse (ip_valid or non_ip_valid) is issued per started frame.
//   clk : core clock
//   rst : asynchronous reset, active-low
//   bus : eth_ip_dst_extractor_if.slave (rx_valid/rx_data in, decision out)
module eth_ip_dst_extractor
    import eth_pkg::*;
#(
    parameter int unsigned RGMII_W = 8,
    parameter int unsigned CNT_W   = 6,
    parameter bit          VLAN_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    eth_ip_dst_extractor_if.slave bus
);

    ip_extract_state_t state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  l3_q, l3_d;
    logic [15:0]       type_q, type_d;
    logic              rx_valid_q;

    logic              ip_valid_q, ip_valid_d;
    logic              non_ip_valid_q, non_ip_valid_d;
    logic              ip_is_ipv6_q, ip_is_ipv6_d;
    logic              trunc_q, trunc_d;
    logic [127:0]      dst_ip_q, dst_ip_d;

    logic [RGMII_W-1:0] rx_word;
    logic [7:0]         rx_byte;
    logic               rx_valid;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   rel;
    logic [15:0]        etype;
    logic               shift_en;
    logic               shift_clr;
    logic [127:0]       word;
    logic               unused_word_msb;

    assign rx_word  = bus.rx_data;
    assign rx_byte  = rx_word[7:0];
    assign rx_valid = bus.rx_valid;

    // The newest byte completes each address, so the published value is the
    // accumulator contents plus the byte being accepted this cycle.
    assign unused_word_msb = ^word[127:120];

    byte_shift_capture #(
        .WIDTH (128)
    ) u_dst_capture (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .clr      (shift_clr),
        .byte_in  (rx_byte),
        .word_out (word)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        l3_d           = l3_q;
        type_d         = type_q;
        ip_valid_d     = 1'b0;
        non_ip_valid_d = 1'b0;
        ip_is_ipv6_d   = ip_is_ipv6_q;
        trunc_d        = trunc_q;
        dst_ip_d       = dst_ip_q;
        shift_en       = 1'b0;
        shift_clr      = 1'b0;

        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        // Offset relative to the L3 header; only meaningful in IPV4/IPV6,
        // which are always entered with cnt_q == l3_q.
        rel     = cnt_q - l3_q;
        etype   = {type_q[7:0], rx_byte};

        case (state_q)
            IDLE: begin
                // rx_valid_q resets high, so a frame already in flight at
                // reset release never looks like a rising edge.
                if (rx_valid && !rx_valid_q) begin
                    state_d   = ETH_HDR;
                    cnt_d     = CNT_W'(1);
                    type_d    = '0;
                    shift_clr = 1'b1;
                end
            end

            ETH_HDR, VLAN: begin
                if (!rx_valid) begin
                    non_ip_valid_d = 1'b1;
                    trunc_d        = 1'b1;
                    state_d        = IDLE;
                end else begin
                    cnt_d  = cnt_inc;
                    type_d = etype;
                    if ((state_q == ETH_HDR && cnt_q == CNT_W'(ETH_HDR_LEN - 1)) ||
                        (state_q == VLAN && cnt_q == CNT_W'(ETH_HDR_LEN + VLAN_TAG_LEN - 1))) begin
                        l3_d = (state_q == VLAN) ? CNT_W'(ETH_HDR_LEN + VLAN_TAG_LEN)
                                                 : CNT_W'(ETH_HDR_LEN);
                        if (etype == ETHERTYPE_VLAN && VLAN_EN && state_q == ETH_HDR) begin
                            state_d = VLAN;
                        end else if (etype == ETHERTYPE_IPV4) begin
                            state_d = IPV4;
                        end else if (etype == ETHERTYPE_IPV6) begin
                            state_d = IPV6;
                        end else begin
                            non_ip_valid_d = 1'b1;
                            trunc_d        = 1'b0;
                            state_d        = WAIT_END;
                        end
                    end
                end
            end

            IPV4: begin
                if (!rx_valid) begin
                    non_ip_valid_d = 1'b1;
                    trunc_d        = 1'b1;
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (rel == '0) begin
                        if (ip_version(rx_byte) != 4'd4) begin
                            non_ip_valid_d = 1'b1;
                            trunc_d        = 1'b0;
                            state_d        = WAIT_END;
                        end
                    end else if (rel >= CNT_W'(IPV4_DST_OFS)) begin
                        shift_en = 1'b1;
                        if (rel == CNT_W'(IPV4_DST_OFS + IPV4_ADDR_BYTES - 1)) begin
                            ip_valid_d      = 1'b1;
                            ip_is_ipv6_d    = 1'b0;
                            trunc_d         = 1'b0;
                            dst_ip_d        = '0;
                            dst_ip_d[31:0]  = {word[23:0], rx_byte};
                            state_d         = WAIT_END;
                        end
                    end
                end
            end

            IPV6: begin
                if (!rx_valid) begin
                    non_ip_valid_d = 1'b1;
                    trunc_d        = 1'b1;
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (rel == '0) begin
                        if (ip_version(rx_byte) != 4'd6) begin
                            non_ip_valid_d = 1'b1;
                            trunc_d        = 1'b0;
                            state_d        = WAIT_END;
                        end
                    end else if (rel >= CNT_W'(IPV6_DST_OFS)) begin
                        shift_en = 1'b1;
                        if (rel == CNT_W'(IPV6_DST_OFS + IPV6_ADDR_BYTES - 1)) begin
                            ip_valid_d   = 1'b1;
                            ip_is_ipv6_d = 1'b1;
                            trunc_d      = 1'b0;
                            dst_ip_d     = {word[119:0], rx_byte};
                            state_d      = WAIT_END;
                        end
                    end
                end
            end

            WAIT_END: begin
                if (!rx_valid) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            l3_q           <= '0;
            type_q         <= '0;
            rx_valid_q     <= 1'b1;
            ip_valid_q     <= 1'b0;
            non_ip_valid_q <= 1'b0;
            ip_is_ipv6_q   <= 1'b0;
            trunc_q        <= 1'b0;
            dst_ip_q       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            l3_q           <= l3_d;
            type_q         <= type_d;
            rx_valid_q     <= rx_valid;
            ip_valid_q     <= ip_valid_d;
            non_ip_valid_q <= non_ip_valid_d;
            ip_is_ipv6_q   <= ip_is_ipv6_d;
            trunc_q        <= trunc_d;
            dst_ip_q       <= dst_ip_d;
        end
    end

    assign bus.ip_valid     = ip_valid_q;
    assign bus.non_ip_valid = non_ip_valid_q;
    assign bus.ip_is_ipv6   = ip_is_ipv6_q;
    assign bus.trunc        = trunc_q;
    assign bus.dst_ip       = dst_ip_q;

endmodule

// File: tb/tb_eth_ip_dst_extractor.sv
// Scoreboard bench for eth_ip_dst_extractor: the frame driver pushes the
// expected decision (kind, fields, arrival tick) when it drives the deciding
// byte; an independent monitor pops and compares on every decision pulse.
module tb_eth_ip_dst_extractor;

    typedef struct {
        bit           is_ip;
        bit           is6;
        logic [127:0] dst;
        bit           trunc;
        int unsigned  tick;
    } exp_t;

    logic        clk;
    logic        rst;
    int unsigned tick;
    int unsigned n_assert;
    int unsigned n_fail;
    exp_t        exp_q[$];
    logic [7:0]  frm[$];

    eth_ip_dst_extractor_if #(.RGMII_W(8)) bus ();

    eth_ip_dst_extractor #(
        .RGMII_W (8),
        .CNT_W   (6),
        .VLAN_EN (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial tick = 0;
    always @(posedge clk) tick <= tick + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.ip_valid || bus.non_ip_valid) begin
                chk("single_pulse", {127'b0, bus.ip_valid && bus.non_ip_valid}, 128'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {127'b0, bus.ip_valid}, {127'b0, bus.non_ip_valid});
                    if (bus.ip_valid && bus.non_ip_valid) begin
                        chk("unexpected_pulse_any", 128'd1, 128'd0);
                    end
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_tick", 128'(tick), 128'(e.tick));
                    chk("kind_ip", {127'b0, bus.ip_valid}, {127'b0, e.is_ip});
                    if (e.is_ip) begin
                        chk("ip_is_ipv6", {127'b0, bus.ip_is_ipv6}, {127'b0, e.is6});
                        chk("dst_ip", bus.dst_ip, e.dst);
                    end else begin
                        chk("trunc", {127'b0, bus.trunc}, {127'b0, e.trunc});
                    end
                end
            end
        end
    end

    task automatic hdr(input bit vlan, input logic [15:0] etype);
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(8'h02 + 8'(i));
        for (int i = 0; i < 6; i++) frm.push_back(8'h50 + 8'(i));
        if (vlan) begin
            frm.push_back(8'h81); frm.push_back(8'h00);
            frm.push_back(8'h00); frm.push_back(8'h05);
        end
        frm.push_back(etype[15:8]);
        frm.push_back(etype[7:0]);
    endtask

    task automatic ipv4(input logic [7:0] b0, input logic [31:0] dst, input int pay);
        frm.push_back(b0);
        for (int i = 1; i < 12; i++) frm.push_back(8'hA0 + 8'(i));
        frm.push_back(8'h0A); frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h01);
        for (int i = 3; i >= 0; i--) frm.push_back(dst[i*8 +: 8]);
        for (int i = 0; i < pay; i++) frm.push_back(8'hE0 + 8'(i));
    endtask

    task automatic ipv6(input logic [127:0] dst, input int pay);
        frm.push_back(8'h60);
        for (int i = 1; i < 8; i++) frm.push_back(8'hB0 + 8'(i));
        for (int i = 0; i < 16; i++) frm.push_back(8'hC0 + 8'(i));
        for (int i = 15; i >= 0; i--) frm.push_back(dst[i*8 +: 8]);
        for (int i = 0; i < pay; i++) frm.push_back(8'hE0 + 8'(i));
    endtask

    // Drives frm then one idle cycle; index frm.size() is that idle cycle.
    task automatic send_frame(input int unsigned dec_idx, input exp_t e);
        exp_t ex;
        for (int unsigned i = 0; i <= frm.size(); i++) begin
            @(negedge clk);
            if (i < frm.size()) begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = frm[i];
            end else begin
                bus.rx_valid = 1'b0;
                bus.rx_data  = 8'h00;
            end
            if (i == dec_idx) begin
                ex      = e;
                ex.tick = tick + 1;
                exp_q.push_back(ex);
            end
        end
    endtask

    function automatic exp_t mk_ip(input bit is6, input logic [127:0] dst);
        exp_t e;
        e.is_ip = 1'b1; e.is6 = is6; e.dst = dst; e.trunc = 1'b0; e.tick = 0;
        return e;
    endfunction

    function automatic exp_t mk_non(input bit tr);
        exp_t e;
        e.is_ip = 1'b0; e.is6 = 1'b0; e.dst = '0; e.trunc = tr; e.tick = 0;
        return e;
    endfunction

    localparam logic [127:0] V6_A = 128'h20010DB8_00000000_00000000_00000001;
    localparam logic [127:0] V6_B = 128'hFE800000_00000000_02AABBFF_FECCDDEE;

    initial begin
        rst          = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        n_assert     = 0;
        n_fail       = 0;

        repeat (3) @(negedge clk);
        chk("rst_ip_valid", {127'b0, bus.ip_valid}, 128'd0);
        chk("rst_non_ip_valid", {127'b0, bus.non_ip_valid}, 128'd0);
        chk("rst_ip_is_ipv6", {127'b0, bus.ip_is_ipv6}, 128'd0);
        chk("rst_trunc", {127'b0, bus.trunc}, 128'd0);
        chk("rst_dst_ip", bus.dst_ip, 128'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Untagged IPv4, 192.168.1.10
        hdr(1'b0, 16'h0800); ipv4(8'h45, 32'hC0A8010A, 6);
        send_frame(33, mk_ip(1'b0, 128'h0000_0000_0000_0000_0000_0000_C0A8_010A));
        // Untagged IPv6, 2001:db8::1 (back-to-back after one idle)
        hdr(1'b0, 16'h86DD); ipv6(V6_A, 4);
        send_frame(53, mk_ip(1'b1, V6_A));
        // ARP
        hdr(1'b0, 16'h0806); for (int i = 0; i < 28; i++) frm.push_back(8'(i));
        send_frame(13, mk_non(1'b0));
        // Tagged IPv4
        hdr(1'b1, 16'h0800); ipv4(8'h45, 32'h0A000007, 3);
        send_frame(37, mk_ip(1'b0, 128'h0000_0000_0000_0000_0000_0000_0A00_0007));
        // Tagged IPv6: latest decision point (offset 57)
        hdr(1'b1, 16'h86DD); ipv6(V6_B, 2);
        send_frame(57, mk_ip(1'b1, V6_B));
        // IPv4 truncated after 25 bytes
        hdr(1'b0, 16'h0800); ipv4(8'h45, 32'h01020304, 0);
        while (frm.size() > 25) void'(frm.pop_back());
        send_frame(25, mk_non(1'b1));
        // Type 0x0800 carrying version 6
        hdr(1'b0, 16'h0800); ipv4(8'h65, 32'h05060708, 2);
        send_frame(14, mk_non(1'b0));
        // Double VLAN tag
        hdr(1'b1, 16'h8100); for (int i = 0; i < 30; i++) frm.push_back(8'h45);
        send_frame(17, mk_non(1'b0));
        // Last dst byte is the last frame byte: normal decision, not truncation
        hdr(1'b0, 16'h0800); ipv4(8'h45, 32'hDEADBEEF, 0);
        send_frame(33, mk_ip(1'b0, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF));
        // Truncated in the Ethernet header
        hdr(1'b0, 16'h0800); while (frm.size() > 9) void'(frm.pop_back());
        send_frame(9, mk_non(1'b1));

        // Reset at offset 20 of an IPv4 frame; stream keeps going through release
        hdr(1'b0, 16'h0800); ipv4(8'h45, 32'h0B0B0B0B, 20);
        for (int unsigned i = 0; i < frm.size(); i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b1;
            bus.rx_data  = frm[i];
            if (i == 20) begin
                #2 rst = 1'b0;
                #1;
                chk("midrst_ip_valid", {127'b0, bus.ip_valid}, 128'd0);
                chk("midrst_non_ip_valid", {127'b0, bus.non_ip_valid}, 128'd0);
                chk("midrst_trunc", {127'b0, bus.trunc}, 128'd0);
                chk("midrst_dst_ip", bus.dst_ip, 128'd0);
            end
            if (i == 24) rst = 1'b1;
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        @(negedge clk);
        chk("post_rst_dst_ip", bus.dst_ip, 128'd0);

        // Next frame after the ignored one decodes normally
        hdr(1'b0, 16'h0800); ipv4(8'h45, 32'hC0A80164, 1);
        send_frame(33, mk_ip(1'b0, 128'h0000_0000_0000_0000_0000_0000_C0A8_0164));

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("missing_pulse", 128'd0, 128'(e.tick));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
